chaos_iter_ctrl: RTL

CHAOS_ITER_CTRL -- requirements
Module: chaos_iter_ctrl

---
 rtl/chaos_iter_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/chaos_iter_ctrl.sv
// chaos_iter_ctrl
// Sequences iterations of the logistic map x <- mu * x * (1 - x) in unsigned
// 2.16 fixed point. Each iteration uses two products, both borrowed from an
// external shared multiplier through a req/ack handshake.
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous reset, active low
//   start      begin a run (taken only when not busy)
//   step_en    one-cycle pacing strobe; starts one iteration from WAIT_STEP
//   mu, x0     map parameter and initial value, latched at start
//   maxrepeat  number of iterates in the run, latched at start
//   mul_req    multiplier request; mul_a/mul_b are zero whenever it is low
//   mul_a/b    multiplier operands, held stable while mul_req is high
//   mul_ack    multiplier result valid (only honoured while requesting)
//   mul_p      full-width unsigned product
//   x_out      latest iterate; x_valid pulses once per new iterate
//   iter       iterates emitted so far in the current run
//   busy       run in progress; done pulses once on entry to DONE
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | after reset, waiting for start
// WAIT_STEP | run active, waiting for step_en
// MUL1      | requesting x * (1 - x)
// MUL2      | one idle cycle with mul_req low, then requesting mu * t
// EMIT      | x_out/x_valid presented, decide on next iteration or DONE
// DONE      | run finished, outputs held, waiting for start
module chaos_iter_ctrl #(
    parameter int W = 18
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    input  logic           step_en,
    input  logic [W-1:0]   mu,
    input  logic [W-1:0]   x0,
    input  logic [9:0]     maxrepeat,
    output logic           mul_req,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic           mul_ack,
    input  logic [2*W-1:0] mul_p,
    output logic [W-1:0]   x_out,
    output logic           x_valid,
    output logic [9:0]     iter,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_STEP, S_MUL1, S_MUL2, S_EMIT, S_DONE
    } state_t;

    localparam logic [W-1:0] FX_ONE = W'(17'h10000);

    state_t       state, state_next;
    logic [W-1:0] mu_r, x_r, t_r, t_in;
    logic [9:0]   maxrep_r;
    logic         load_run, go_mul1, cap_t, issue_mul2, cap_x, enter_done;

    // Drop the 2.16 fraction tail; integer overflow saturates to all-ones.
    function automatic logic [W-1:0] rnd(input logic [2*W-1:0] p);
        if (|p[2*W-1:W+16]) rnd = '1;
        else                rnd = p[W+15:16];
    endfunction

    // 1 - x, floored at zero for x above 1.0
    assign t_in = (x_r > FX_ONE) ? '0 : (FX_ONE - x_r);

    always_ff @(posedge CLK) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_run   = 1'b0;
        go_mul1    = 1'b0;
        cap_t      = 1'b0;
        issue_mul2 = 1'b0;
        cap_x      = 1'b0;
        enter_done = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load_run = 1'b1;
                    if (maxrepeat == '0) begin
                        state_next = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_next = S_WAIT_STEP;
                    end
                end
            end
            S_WAIT_STEP: begin
                if (step_en) begin
                    go_mul1    = 1'b1;
                    state_next = S_MUL1;
                end
            end
            S_MUL1: begin
                if (mul_req && mul_ack) begin
                    cap_t      = 1'b1;
                    state_next = S_MUL2;
                end
            end
            S_MUL2: begin
                // mul_req is low on the first MUL2 cycle so the previous
                // request is seen to end before the next one begins.
                if (!mul_req) begin
                    issue_mul2 = 1'b1;
                end else if (mul_ack) begin
                    cap_x      = 1'b1;
                    state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                // iter already counts the iterate being emitted
                if (iter == maxrep_r) begin
                    state_next = S_DONE;
                    enter_done = 1'b1;
                end else begin
                    state_next = S_WAIT_STEP;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            mu_r     <= '0;
            x_r      <= '0;
            t_r      <= '0;
            maxrep_r <= '0;
            iter     <= '0;
            x_out    <= '0;
            mul_req  <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            done     <= 1'b0;
        end else begin
            done <= enter_done;
            if (load_run) begin
                mu_r     <= mu;
                x_r      <= x0;
                maxrep_r <= maxrepeat;
                iter     <= '0;
            end
            if (go_mul1) begin
                mul_req <= 1'b1;
                mul_a   <= x_r;
                mul_b   <= t_in;
            end
            if (cap_t) begin
                t_r     <= rnd(mul_p);
                mul_req <= 1'b0;
                mul_a   <= '0;
                mul_b   <= '0;
            end
            if (issue_mul2) begin
                mul_req <= 1'b1;
                mul_a   <= mu_r;
                mul_b   <= t_r;
            end
            if (cap_x) begin
                x_r     <= rnd(mul_p);
                x_out   <= rnd(mul_p);
                iter    <= iter + 10'd1;
                mul_req <= 1'b0;
                mul_a   <= '0;
                mul_b   <= '0;
            end
        end
    end

    assign x_valid = (state == S_EMIT);
    assign busy    = (state == S_WAIT_STEP) || (state == S_MUL1) ||
                     (state == S_MUL2) || (state == S_EMIT);

endmodule
